spi_erase_seq: RTL and testbench
================================

SPI_ERASE_SEQ -- requirements
Module: spi_erase_seq

Interface
- REQ-001 SHALL have parameter SECTOR_ADDR, default 24'h000000: flash address of the sector to erase.
- REQ-002 SHALL have parameter CMD_WREN, default 8'h06: write-enable opcode.
- REQ-003 SHALL have parameter CMD_SE, default 8'hD8: sector-erase opcode.
- REQ-004 SHALL have parameter CMD_RDSR, default 8'h05: read-status opcode.
- REQ-005 SHALL have parameter GAP, default 4: idle cycles between commands (CS-high time), range 1..255.
- REQ-006 SHALL have parameter POLL_MAX, default 20'd1000000: maximum RDSR polls before timeout.
- REQ-007 SHALL have port sclk, input, 1: sole clock, rising edge.
- REQ-008 SHALL have port rst_n, input, 1: asynchronous active-low reset.
- REQ-009 SHALL have port flag, input, 1: one-cycle debounced key pulse, start request.
- REQ-010 SHALL have port spi_req, output, 1: command request to the SPI byte engine.
- REQ-011 SHALL have port spi_cmd, output, 8: opcode for the current request.
- REQ-012 SHALL have port spi_addr, output, 24: address for the current request.
- REQ-013 SHALL have port spi_addr_en, output, 1: 1 = send the 3-byte address after the opcode.
- REQ-014 SHALL have port spi_rd_en, output, 1: 1 = read one data byte after the opcode.
- REQ-015 SHALL have port spi_ack, input, 1: one-cycle pulse, current request complete.
- REQ-016 SHALL have port spi_rdata, input, 8: read byte, valid in the spi_ack cycle.
- REQ-017 SHALL have port busy, output, 1: high whenever the state is not IDLE.
- REQ-018 SHALL have port done, output, 1: one-cycle pulse, erase finished successfully.
- REQ-019 SHALL have port err, output, 1: one-cycle pulse, poll timeout.

Function
- REQ-020 SHALL implement the states IDLE, WREN, GAP1, ERASE, GAP2, POLL, PGAP and FIN.
- REQ-021 SHALL move IDLE->WREN on the cycle after flag=1 is sampled in IDLE.
- REQ-022 SHALL ignore flag in every state except IDLE, with no queuing.
- REQ-023 SHALL, in WREN, present spi_cmd=CMD_WREN, spi_addr_en=0, spi_rd_en=0.
- REQ-024 SHALL, in ERASE, present spi_cmd=CMD_SE, spi_addr=SECTOR_ADDR, spi_addr_en=1, spi_rd_en=0.
- REQ-025 SHALL, in POLL, present spi_cmd=CMD_RDSR, spi_addr_en=0, spi_rd_en=1.
- REQ-026 SHALL assert spi_req in the first cycle of WREN, ERASE or POLL and hold it high until spi_ack is sampled.
- REQ-027 SHALL drop spi_req in the cycle after spi_ack and keep spi_cmd, spi_addr and the enables stable while spi_req=1.
- REQ-028 SHALL ignore spi_ack when spi_req=0.
- REQ-029 SHALL exit on spi_ack as follows: WREN->GAP1, ERASE->GAP2, POLL->PGAP.
- REQ-030 SHALL hold spi_req=0 in GAP1, GAP2 and PGAP for exactly GAP cycles, using an 8-bit gap counter cleared on every entry.
- REQ-031 SHALL exit the gap states as follows: GAP1->ERASE, GAP2->POLL.
- REQ-032 SHALL capture spi_rdata in the POLL spi_ack cycle and count that poll in a 20-bit counter cleared on WREN entry.
- REQ-033 SHALL, at PGAP end with captured bit0=0, go to FIN.
- REQ-034 SHALL, at PGAP end with bit0=1 and poll count<POLL_MAX, return to POLL.
- REQ-035 SHALL, at PGAP end with bit0=1 and poll count=POLL_MAX, pulse err for one cycle and go to IDLE.
- REQ-036 SHALL pulse done for one cycle in FIN, then go to IDLE.
- REQ-037 SHALL ensure done and err are never high in the same cycle.
- REQ-038 SHALL make busy a registered output that is 0 only in IDLE.
- REQ-039 SHALL, when flag arrives in the same cycle as the FIN->IDLE transition, ignore that flag.

Reset
- REQ-040 SHALL, on rst_n=0, asynchronously force state IDLE and clear both counters and the captured status.
- REQ-041 SHALL, on rst_n=0, drive spi_req=0, spi_cmd=8'h00, spi_addr=24'h0, spi_addr_en=0, spi_rd_en=0, busy=0, done=0, err=0.
- REQ-042 SHALL, on reset mid-sequence including while spi_req=1, abandon the sequence with no done or err pulse.
- REQ-043 SHALL require a new flag after reset release to start a sequence.

Verification
- REQ-044 SHALL cover the nominal sequence: flag pulse, each ack 3 cycles after req, rdata 8'h03 then 8'h02. Required response: req order 06, D8 (addr 000000, addr_en=1), 05, 05; each gap exactly 4 cycles; done pulses once; busy falls with done.
- REQ-045 SHALL cover a delayed ack: ack withheld 50 cycles. Required response: spi_req and spi_cmd stay constant for all 50 cycles; req drops the cycle after ack.
- REQ-046 SHALL cover timeout with POLL_MAX=3 and rdata always 8'h01. Required response: exactly 3 RDSR requests, then a single err pulse, no done, return to IDLE.
- REQ-047 SHALL cover a flag pulse during GAP2 and during POLL. Required response: no extra WREN; exactly one sequence completes.
- REQ-048 SHALL cover reset during ERASE with spi_req=1. Required response: all outputs reach reset values immediately; no done or err; a following flag starts a fresh WREN.
- REQ-049 SHALL cover a stray spi_ack pulse in IDLE. Required response: no state change, outputs unchanged.

Source files
------------

// File: rtl/spi_erase_seq.sv
// Sector-erase sequencer for an SPI flash byte engine:
// WREN, SE, then RDSR polling until WIP clears or the poll budget runs out.
module spi_erase_seq #(
  parameter logic [23:0] SECTOR_ADDR = 24'h000000,
  parameter logic [7:0]  CMD_WREN    = 8'h06,
  parameter logic [7:0]  CMD_SE      = 8'hD8,
  parameter logic [7:0]  CMD_RDSR    = 8'h05,
  parameter int unsigned GAP         = 4,
  parameter logic [19:0] POLL_MAX    = 20'd1000000
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        flag,
  output logic        spi_req,
  output logic [7:0]  spi_cmd,
  output logic [23:0] spi_addr,
  output logic        spi_addr_en,
  output logic        spi_rd_en,
  input  logic        spi_ack,
  input  logic [7:0]  spi_rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_WREN, S_GAP1, S_ERASE,
    S_GAP2, S_POLL, S_PGAP, S_FIN
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

  state_t      state_q, state_d;
  logic [7:0]  gap_q, gap_d;
  logic [19:0] poll_q, poll_d;
  logic [7:0]  stat_q, stat_d;
  logic        req_q, req_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [23:0] addr_q, addr_d;
  logic        aen_q, aen_d;
  logic        ren_q, ren_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic ack;
  logic gap_end;

  assign ack     = req_q & spi_ack;
  assign gap_end = (gap_q == GAP_LAST);

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    poll_d  = poll_q;
    stat_d  = stat_q;
    req_d   = req_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    aen_d   = aen_q;
    ren_d   = ren_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (flag) begin
          state_d = S_WREN;
          req_d   = 1'b1;
          cmd_d   = CMD_WREN;
          aen_d   = 1'b0;
          ren_d   = 1'b0;
          poll_d  = '0;
          busy_d  = 1'b1;
        end
      end
      S_WREN: begin
        if (ack) begin
          state_d = S_GAP1;
          req_d   = 1'b0;
          gap_d   = '0;
        end
      end
      S_GAP1: begin
        if (gap_end) begin
          state_d = S_ERASE;
          req_d   = 1'b1;
          cmd_d   = CMD_SE;
          addr_d  = SECTOR_ADDR;
          aen_d   = 1'b1;
          ren_d   = 1'b0;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      S_ERASE: begin
        if (ack) begin
          state_d = S_GAP2;
          req_d   = 1'b0;
          gap_d   = '0;
        end
      end
      S_GAP2: begin
        if (gap_end) begin
          state_d = S_POLL;
          req_d   = 1'b1;
          cmd_d   = CMD_RDSR;
          aen_d   = 1'b0;
          ren_d   = 1'b1;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      S_POLL: begin
        if (ack) begin
          state_d = S_PGAP;
          req_d   = 1'b0;
          gap_d   = '0;
          stat_d  = spi_rdata;
          poll_d  = poll_q + 20'd1;
        end
      end
      S_PGAP: begin
        if (!gap_end) begin
          gap_d = gap_q + 8'd1;
        end else if (!stat_q[0]) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else if (poll_q < POLL_MAX) begin
          state_d = S_POLL;
          req_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      poll_q  <= '0;
      stat_q  <= '0;
      req_q   <= 1'b0;
      cmd_q   <= '0;
      addr_q  <= '0;
      aen_q   <= 1'b0;
      ren_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      poll_q  <= poll_d;
      stat_q  <= stat_d;
      req_q   <= req_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      aen_q   <= aen_d;
      ren_q   <= ren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign spi_req     = req_q;
  assign spi_cmd     = cmd_q;
  assign spi_addr    = addr_q;
  assign spi_addr_en = aen_q;
  assign spi_rd_en   = ren_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_spi_erase_seq.sv
// Bench for spi_erase_seq: random ack latency and status bytes,
// expected requests and end events queued by a model, checked by a monitor.
module tb_spi_erase_seq;

  localparam logic [23:0] SA  = 24'h000000;
  localparam int          GP  = 4;
  localparam int          PM  = 3;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic        aen;
    logic        ren;
  } req_t;

  logic        sclk = 1'b0;
  logic        rst_n;
  logic        flag;
  logic        spi_req;
  logic [7:0]  spi_cmd;
  logic [23:0] spi_addr;
  logic        spi_addr_en;
  logic        spi_rd_en;
  logic        spi_ack;
  logic [7:0]  spi_rdata;
  logic        busy;
  logic        done;
  logic        err;

  spi_erase_seq #(
    .SECTOR_ADDR(SA),
    .GAP(GP),
    .POLL_MAX(20'(PM))
  ) dut (
    .sclk(sclk),
    .rst_n(rst_n),
    .flag(flag),
    .spi_req(spi_req),
    .spi_cmd(spi_cmd),
    .spi_addr(spi_addr),
    .spi_addr_en(spi_addr_en),
    .spi_rd_en(spi_rd_en),
    .spi_ack(spi_ack),
    .spi_rdata(spi_rdata),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 sclk = ~sclk;

  int n_chk = 0;
  int n_fail = 0;

  req_t exp_req[$];
  byte  exp_end[$];

  logic [7:0] rd_arr [8];
  int         ack_delay = 3;
  int         stray_req = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: WREN, SE, then one RDSR per status byte until WIP clears
  // or the poll budget is spent.
  task automatic build_model();
    exp_req.push_back('{8'h06, 24'h0, 1'b0, 1'b0});
    exp_req.push_back('{8'hD8, SA, 1'b1, 1'b0});
    for (int i = 0; i < PM; i++) begin
      exp_req.push_back('{8'h05, 24'h0, 1'b0, 1'b1});
      if (rd_arr[i][0] == 1'b0) begin
        exp_end.push_back("D");
        break;
      end
      if (i == PM - 1) exp_end.push_back("E");
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic start_seq(input logic [7:0] r0, input logic [7:0] r1,
                           input logic [7:0] r2, input int dly);
    rd_arr[0] = r0;
    rd_arr[1] = r1;
    rd_arr[2] = r2;
    ack_delay = dly;
    build_model();
    tick();
    flag = 1'b1;
    tick();
    flag = 1'b0;
    chk("busy_rise", busy, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 4000) begin
      tick();
      n++;
    end
    chk("seq_timeout", 64'(n >= 4000), 0);
    repeat (3) tick();
    chk("busy_idle", busy, 0);
    chk("exp_req_left", 64'(exp_req.size()), 0);
    chk("exp_end_left", 64'(exp_end.size()), 0);
  endtask

  task automatic flag_once();
    flag = 1'b1;
    tick();
    flag = 1'b0;
  endtask

  // Flash byte-engine stand-in
  initial begin
    int w = 0;
    int dly = 1;
    int rd_idx = 0;
    int stray_done = 0;
    spi_ack = 1'b0;
    spi_rdata = 8'h00;
    forever begin
      tick();
      spi_ack = 1'b0;
      if (!busy) rd_idx = 0;
      if (stray_req != stray_done) begin
        stray_done++;
        spi_ack = 1'b1;
        spi_rdata = 8'($urandom);
      end else if (spi_req && rst_n) begin
        if (w == 0) dly = (ack_delay != 0) ? ack_delay : $urandom_range(1, 6);
        w++;
        if (w >= dly) begin
          w = 0;
          spi_ack = 1'b1;
          if (spi_cmd == 8'h05 && rd_idx < 8) begin
            spi_rdata = rd_arr[rd_idx];
            rd_idx++;
          end else begin
            spi_rdata = 8'($urandom);
          end
        end
      end else begin
        w = 0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic prev_req = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_ack = 1'b0;
    logic prev_done = 1'b0;
    req_t prev_bus = '0;
    req_t cur;
    req_t e;
    int low_cnt = 0;
    forever begin
      @(negedge sclk);
      if (!rst_n) begin
        prev_req = 1'b0;
        prev_busy = 1'b0;
        prev_ack = 1'b0;
        prev_done = 1'b0;
        low_cnt = 0;
        continue;
      end
      cur = '{spi_cmd, spi_addr, spi_addr_en, spi_rd_en};
      if (spi_req && !prev_req) begin
        if (prev_busy) chk("gap_len", 64'(low_cnt), 64'(GP));
        if (exp_req.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_req: got cmd %0h expected none", spi_cmd);
        end else begin
          e = exp_req.pop_front();
          if (!e.aen) begin
            e.addr = 24'h0;
            cur.addr = 24'h0;
          end
          chk("req_fields", 64'(cur), 64'(e));
        end
        low_cnt = 0;
      end else if (spi_req && prev_req) begin
        chk("req_stable", 64'(cur), 64'(prev_bus));
      end
      if (prev_req && prev_ack) chk("req_drop", spi_req, 0);
      if (!spi_req && busy) low_cnt++;
      if (prev_done) chk("busy_after_done", busy, 0);
      if (done || err) begin
        chk("done_err_excl", done & err, 0);
        if (exp_end.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_end: got done=%0b err=%0b expected none",
                   done, err);
        end else begin
          chk("end_kind", done ? 64'h44 : 64'h45, 64'(exp_end.pop_front()));
        end
        if (err) chk("busy_at_err", busy, 0);
      end
      prev_req = spi_req;
      prev_busy = busy;
      prev_ack = spi_ack;
      prev_done = done;
      prev_bus = '{spi_cmd, spi_addr, spi_addr_en, spi_rd_en};
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    flag = 1'b0;
    repeat (3) tick();
    chk("rst_req", spi_req, 0);
    chk("rst_cmd", spi_cmd, 0);
    chk("rst_addr", spi_addr, 0);
    chk("rst_aen", spi_addr_en, 0);
    chk("rst_ren", spi_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_no_flag", busy, 0);

    // stray ack while idle
    stray_req++;
    repeat (4) tick();
    chk("stray_busy", busy, 0);
    chk("stray_req", spi_req, 0);
    chk("stray_cmd", spi_cmd, 0);

    // nominal
    start_seq(8'h03, 8'h02, 8'h00, 3);
    wait_idle();

    // withheld ack
    start_seq(8'h00, 8'h00, 8'h00, 50);
    wait_idle();

    // poll timeout
    start_seq(8'h01, 8'h01, 8'h01, 0);
    wait_idle();

    // flag during GAP2 and during POLL
    start_seq(8'h01, 8'h01, 8'h00, 0);
    n = 0;
    while (!(spi_cmd == 8'hD8 && !spi_req) && n < 500) begin
      tick();
      n++;
    end
    chk("reach_gap2", 64'(n >= 500), 0);
    flag_once();
    n = 0;
    while (!(spi_cmd == 8'h05 && spi_req) && n < 500) begin
      tick();
      n++;
    end
    chk("reach_poll", 64'(n >= 500), 0);
    flag_once();
    wait_idle();

    // flag coinciding with the FIN->IDLE step
    start_seq(8'h00, 8'h00, 8'h00, 2);
    n = 0;
    while (!done && n < 500) begin
      tick();
      n++;
    end
    chk("reach_fin", 64'(n >= 500), 0);
    flag_once();
    wait_idle();

    // reset during ERASE with request outstanding
    start_seq(8'h00, 8'h00, 8'h00, 5);
    n = 0;
    while (!(spi_cmd == 8'hD8 && spi_req) && n < 500) begin
      tick();
      n++;
    end
    chk("reach_erase", 64'(n >= 500), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", spi_req, 0);
    chk("mid_rst_out",
        64'({spi_cmd, spi_addr, spi_addr_en, spi_rd_en, busy, done, err}), 0);
    exp_req.delete();
    exp_end.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_idle", busy, 0);
    start_seq(8'h01, 8'h00, 8'h00, 3);
    wait_idle();

    // random sequences
    for (int k = 0; k < 8; k++) begin
      start_seq(8'($urandom), 8'($urandom), 8'($urandom), 0);
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
